// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: widths, opcodes, exception codes,
// FSM encoding and the data-bus request payload.
package mem_stage_pkg;

  localparam int unsigned REG_BUS        = 32;
  localparam int unsigned DOUBLE_REG_BUS = 64;
  localparam int unsigned REG_ADDR_BUS   = 5;
  localparam int unsigned ALUOP_BUS      = 8;
  localparam int unsigned EXC_CODE_BUS   = 5;
  localparam int unsigned BE_BUS         = 4;

  typedef logic [ALUOP_BUS-1:0]    aluop_t;
  typedef logic [EXC_CODE_BUS-1:0] exc_t;

  localparam aluop_t OP_ADD = 8'h18;
  localparam aluop_t OP_LB  = 8'h90;
  localparam aluop_t OP_LBU = 8'h91;
  localparam aluop_t OP_LH  = 8'h92;
  localparam aluop_t OP_LHU = 8'h93;
  localparam aluop_t OP_LW  = 8'h94;
  localparam aluop_t OP_SB  = 8'h98;
  localparam aluop_t OP_SH  = 8'h99;
  localparam aluop_t OP_SW  = 8'h9A;

  localparam exc_t EXC_NONE = 5'h10;
  localparam exc_t EXC_ADEL = 5'h04;
  localparam exc_t EXC_ADES = 5'h05;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  typedef struct packed {
    logic                we;
    logic [REG_BUS-1:0]  addr;
    logic [BE_BUS-1:0]   be;
    logic [REG_BUS-1:0]  wdata;
  } dbus_req_t;

  function automatic logic is_load(input aluop_t op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input aluop_t op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane selection and sign/zero extension of the returned bus word.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]         addr_i,
  input  aluop_t             aluop_i,
  input  logic [REG_BUS-1:0] word_i,
  output logic [REG_BUS-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (addr_i)
      2'd0: byte_sel = word_i[7:0];
      2'd1: byte_sel = word_i[15:8];
      2'd2: byte_sel = word_i[23:16];
      2'd3: byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = word_i;
    case (aluop_i)
      OP_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data_o = {24'h0, byte_sel};
      OP_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data_o = {16'h0, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-bus accesses, waits for the acknowledge,
// aligns load data and gates writeback on flush or exception.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                      cpu_clk_50M,
  input  logic                      cpu_rst,
  input  logic [ALUOP_BUS-1:0]      mem_aluop_i,
  input  logic [REG_ADDR_BUS-1:0]   mem_wa_i,
  input  logic                      mem_wreg_i,
  input  logic                      mem_mreg_i,
  input  logic [REG_BUS-1:0]        mem_wd_i,
  input  logic [REG_BUS-1:0]        mem_din_i,
  input  logic                      mem_whilo_i,
  input  logic [DOUBLE_REG_BUS-1:0] mem_hilo_i,
  input  logic [EXC_CODE_BUS-1:0]   mem_exccode_i,
  input  logic                      flush_i,
  input  logic                      adv_i,
  output logic                      dreq_o,
  output logic                      dwe_o,
  output logic [REG_BUS-1:0]        daddr_o,
  output logic [BE_BUS-1:0]         dbe_o,
  output logic [REG_BUS-1:0]        dwdata_o,
  input  logic                      dack_i,
  input  logic [REG_BUS-1:0]        drdata_i,
  output logic [REG_ADDR_BUS-1:0]   mem_wa_o,
  output logic                      mem_wreg_o,
  output logic                      mem_mreg_o,
  output logic [REG_BUS-1:0]        mem_dreg_o,
  output logic                      mem_whilo_o,
  output logic [DOUBLE_REG_BUS-1:0] mem_hilo_o,
  output logic                      mem2exe_whilo,
  output logic [DOUBLE_REG_BUS-1:0] mem2exe_hilo,
  output logic [EXC_CODE_BUS-1:0]   mem_exccode_o,
  output logic                      stallreq_mem
);

  mem_state_e         state_q, state_d;
  dbus_req_t          req_q, req_d, req_c, bus_c;
  logic [REG_BUS-1:0] rdata_q;
  logic [REG_BUS-1:0] ld_data;
  logic               is_ld, is_st, misalign, mem_op_c, dreq_c, stall_c, drain_c;
  exc_t               exc_c;

  // Decode, alignment check and bus payload for the current instruction.
  always_comb begin
    is_ld    = is_load(mem_aluop_i);
    is_st    = is_store(mem_aluop_i);
    misalign = 1'b0;
    case (mem_aluop_i)
      OP_LH, OP_LHU, OP_SH: misalign = mem_wd_i[0];
      OP_LW, OP_SW:         misalign = |mem_wd_i[1:0];
      default:              misalign = 1'b0;
    endcase

    if (mem_exccode_i != EXC_NONE) exc_c = mem_exccode_i;
    else if (misalign)             exc_c = is_ld ? EXC_ADEL : EXC_ADES;
    else                           exc_c = EXC_NONE;

    mem_op_c = (is_ld | is_st) & (exc_c == EXC_NONE) & ~flush_i;

    req_c.we    = is_st;
    req_c.addr  = {mem_wd_i[31:2], 2'b00};
    req_c.be    = 4'b1111;
    req_c.wdata = mem_din_i;
    case (mem_aluop_i)
      OP_SB: begin
        case (mem_wd_i[1:0])
          2'd0:    req_c.be = 4'b0001;
          2'd1:    req_c.be = 4'b0010;
          2'd2:    req_c.be = 4'b0100;
          default: req_c.be = 4'b1000;
        endcase
        req_c.wdata = {4{mem_din_i[7:0]}};
      end
      OP_SH: begin
        req_c.be    = mem_wd_i[1] ? 4'b1100 : 4'b0011;
        req_c.wdata = {2{mem_din_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      if (dack_i) rdata_q <= drdata_i;
    end
  end

  // Bus handshake FSM; once raised, the request is held until acknowledged.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    bus_c   = '0;
    dreq_c  = 1'b0;
    stall_c = 1'b0;
    drain_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op_c) begin
          dreq_c = 1'b1;
          bus_c  = req_c;
          req_d  = req_c;
          if (dack_i) begin
            if (!adv_i) state_d = ST_DONE;
          end else begin
            stall_c = 1'b1;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        dreq_c = 1'b1;
        bus_c  = req_q;
        if (dack_i) begin
          state_d = (adv_i | flush_i) ? ST_IDLE : ST_DONE;
        end else begin
          stall_c = 1'b1;
          if (flush_i) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        dreq_c  = 1'b1;
        bus_c   = req_q;
        stall_c = 1'b1;
        drain_c = 1'b1;
        if (dack_i) state_d = ST_IDLE;
      end
      ST_DONE: begin
        if (adv_i | flush_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .addr_i  (mem_wd_i[1:0]),
    .aluop_i (mem_aluop_i),
    .word_i  (dack_i ? drdata_i : rdata_q),
    .data_o  (ld_data)
  );

  // Output drive; everything is forced quiet while reset is held.
  always_comb begin
    dreq_o        = 1'b0;
    dwe_o         = 1'b0;
    daddr_o       = '0;
    dbe_o         = '0;
    dwdata_o      = '0;
    mem_wa_o      = '0;
    mem_wreg_o    = 1'b0;
    mem_mreg_o    = 1'b0;
    mem_dreg_o    = '0;
    mem_whilo_o   = 1'b0;
    mem_hilo_o    = '0;
    mem2exe_whilo = 1'b0;
    mem2exe_hilo  = '0;
    mem_exccode_o = EXC_NONE;
    stallreq_mem  = 1'b0;
    if (!cpu_rst) begin
      dreq_o        = dreq_c;
      dwe_o         = bus_c.we;
      daddr_o       = bus_c.addr;
      dbe_o         = bus_c.be;
      dwdata_o      = bus_c.wdata;
      mem_wa_o      = mem_wa_i;
      mem_wreg_o    = mem_wreg_i & ~flush_i & (exc_c == EXC_NONE) & ~drain_c;
      mem_mreg_o    = mem_mreg_i;
      mem_dreg_o    = is_ld ? ld_data : mem_wd_i;
      mem_whilo_o   = mem_whilo_i & ~flush_i & (exc_c == EXC_NONE) & ~drain_c;
      mem_hilo_o    = mem_hilo_i;
      mem2exe_whilo = mem_whilo_o;
      mem2exe_hilo  = mem_hilo_o;
      mem_exccode_o = exc_c;
      stallreq_mem  = stall_c;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: hand-computed vectors checked with immediate
// assertions, inputs driven on the falling edge and outputs sampled 1 ns later.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [4:0]  wa;
  logic        wreg, mreg;
  logic [31:0] wd, din;
  logic        whilo;
  logic [63:0] hilo;
  logic [4:0]  exc;
  logic        flush, adv, dack;
  logic [31:0] rdata;

  logic        dreq_o, dwe_o;
  logic [31:0] daddr_o, dwdata_o;
  logic [3:0]  dbe_o;
  logic [4:0]  wa_o;
  logic        wreg_o, mreg_o, whilo_o, m2e_whilo;
  logic [31:0] dreg_o;
  logic [63:0] hilo_o, m2e_hilo;
  logic [4:0]  exc_o;
  logic        stall_o;

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .cpu_clk_50M   (clk),
    .cpu_rst       (rst),
    .mem_aluop_i   (aluop),
    .mem_wa_i      (wa),
    .mem_wreg_i    (wreg),
    .mem_mreg_i    (mreg),
    .mem_wd_i      (wd),
    .mem_din_i     (din),
    .mem_whilo_i   (whilo),
    .mem_hilo_i    (hilo),
    .mem_exccode_i (exc),
    .flush_i       (flush),
    .adv_i         (adv),
    .dreq_o        (dreq_o),
    .dwe_o         (dwe_o),
    .daddr_o       (daddr_o),
    .dbe_o         (dbe_o),
    .dwdata_o      (dwdata_o),
    .dack_i        (dack),
    .drdata_i      (rdata),
    .mem_wa_o      (wa_o),
    .mem_wreg_o    (wreg_o),
    .mem_mreg_o    (mreg_o),
    .mem_dreg_o    (dreg_o),
    .mem_whilo_o   (whilo_o),
    .mem_hilo_o    (hilo_o),
    .mem2exe_whilo (m2e_whilo),
    .mem2exe_hilo  (m2e_hilo),
    .mem_exccode_o (exc_o),
    .stallreq_mem  (stall_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vec++;
    assert (obs === expv) else begin
      err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic op_in(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic we);
    aluop = op; wd = a; din = d; wreg = we; mreg = is_load(op);
  endtask

  task automatic bus_in(input logic ack, input logic [31:0] rd);
    dack = ack; rdata = rd;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    // Reset with busy-looking inputs: everything must read as zero.
    rst = 1'b1; wa = 5'd7; whilo = 1'b1; hilo = 64'h0123_4567_89AB_CDEF;
    exc = EXC_NONE; flush = 1'b0; adv = 1'b1;
    op_in(OP_LW, 32'h100, 32'h0, 1'b1); bus_in(1'b1, 32'hDEAD_BEEF);
    tick; #1;
    chk("rst_dreq",  64'(dreq_o), 64'(0));
    chk("rst_dreg",  64'(dreg_o), 64'(0));
    chk("rst_wreg",  64'(wreg_o), 64'(0));
    chk("rst_hilo",  hilo_o, 64'(0));
    chk("rst_wa",    64'(wa_o), 64'(0));
    chk("rst_exc",   64'(exc_o), 64'(EXC_NONE));
    chk("rst_stall", 64'(stall_o), 64'(0));
    whilo = 1'b0; hilo = '0;

    // Zero-wait LW.
    tick; rst = 1'b0; #1;
    chk("lw0_dreq",  64'(dreq_o), 64'(1));
    chk("lw0_addr",  64'(daddr_o), 64'(32'h100));
    chk("lw0_be",    64'(dbe_o), 64'(4'hF));
    chk("lw0_dwe",   64'(dwe_o), 64'(0));
    chk("lw0_dreg",  64'(dreg_o), 64'(32'hDEAD_BEEF));
    chk("lw0_wreg",  64'(wreg_o), 64'(1));
    chk("lw0_wa",    64'(wa_o), 64'(7));
    chk("lw0_stall", 64'(stall_o), 64'(0));

    // ALU pass-through with HI/LO writeback.
    tick; op_in(OP_ADD, 32'h1234_5678, 32'h0, 1'b1); bus_in(1'b0, 32'h0);
    whilo = 1'b1; hilo = 64'hFEDC_BA98_7654_3210; #1;
    chk("alu_stall", 64'(stall_o), 64'(0));
    chk("alu_dreq",  64'(dreq_o), 64'(0));
    chk("alu_dreg",  64'(dreg_o), 64'(32'h1234_5678));
    chk("alu_whilo", 64'(whilo_o), 64'(1));
    chk("alu_hilo",  hilo_o, 64'hFEDC_BA98_7654_3210);
    chk("alu_m2e",   m2e_hilo, 64'hFEDC_BA98_7654_3210);
    tick; flush = 1'b1; #1;
    chk("fl_whilo",  64'(whilo_o), 64'(0));
    chk("fl_m2ew",   64'(m2e_whilo), 64'(0));
    chk("fl_wreg",   64'(wreg_o), 64'(0));
    flush = 1'b0; whilo = 1'b0;

    // LB with three stall cycles, then the same with LBU.
    for (int k = 0; k < 2; k++) begin
      tick; op_in(k == 0 ? OP_LB : OP_LBU, 32'h103, 32'h0, 1'b1); bus_in(1'b0, 32'h0); #1;
      chk("lb_s0",    64'(stall_o), 64'(1));
      chk("lb_dreq",  64'(dreq_o), 64'(1));
      chk("lb_addr",  64'(daddr_o), 64'(32'h100));
      tick; #1; chk("lb_s1", 64'(stall_o), 64'(1));
      tick; #1; chk("lb_s2", 64'(stall_o), 64'(1));
      tick; bus_in(1'b1, 32'h80FF_FFFF); #1;
      chk("lb_s3",    64'(stall_o), 64'(0));
      chk("lb_dreg",  64'(dreg_o), k == 0 ? 64'(32'hFFFF_FF80) : 64'(32'h0000_0080));
      tick; op_in(OP_ADD, 32'h0, 32'h0, 1'b0); bus_in(1'b0, 32'h0); #1;
      chk("lb_idle",  64'(dreq_o), 64'(0));
    end

    // Halfword and byte loads at other lanes, zero-wait.
    tick; op_in(OP_LH,  32'h402, 32'h0, 1'b1); bus_in(1'b1, 32'h8001_7777); #1;
    chk("lh_dreg",  64'(dreg_o), 64'(32'hFFFF_8001));
    tick; op_in(OP_LHU, 32'h402, 32'h0, 1'b1); #1;
    chk("lhu_dreg", 64'(dreg_o), 64'(32'h0000_8001));
    tick; op_in(OP_LB,  32'h101, 32'h0, 1'b1); bus_in(1'b1, 32'h0000_A500); #1;
    chk("lb1_dreg", 64'(dreg_o), 64'(32'hFFFF_FFA5));

    // Stores: SH upper half, SB lane 3, SW.
    tick; op_in(OP_SH, 32'h202, 32'h1234_ABCD, 1'b0); bus_in(1'b1, 32'h0); #1;
    chk("sh_be",    64'(dbe_o), 64'(4'b1100));
    chk("sh_wdata", 64'(dwdata_o), 64'(32'hABCD_ABCD));
    chk("sh_dwe",   64'(dwe_o), 64'(1));
    chk("sh_addr",  64'(daddr_o), 64'(32'h200));
    chk("sh_wreg",  64'(wreg_o), 64'(0));
    tick; op_in(OP_SB, 32'h203, 32'h0000_00EF, 1'b0); #1;
    chk("sb_be",    64'(dbe_o), 64'(4'b1000));
    chk("sb_wdata", 64'(dwdata_o), 64'(32'hEFEF_EFEF));
    tick; op_in(OP_SW, 32'h204, 32'h0BAD_F00D, 1'b0); #1;
    chk("sw_be",    64'(dbe_o), 64'(4'b1111));
    chk("sw_wdata", 64'(dwdata_o), 64'(32'h0BAD_F00D));

    // Misaligned accesses and upstream exception.
    tick; op_in(OP_LW, 32'h101, 32'h0, 1'b1); bus_in(1'b0, 32'h0); #1;
    chk("mis_dreq",  64'(dreq_o), 64'(0));
    chk("mis_exc",   64'(exc_o), 64'(EXC_ADEL));
    chk("mis_wreg",  64'(wreg_o), 64'(0));
    chk("mis_stall", 64'(stall_o), 64'(0));
    tick; #1;
    chk("mis_dreq2", 64'(dreq_o), 64'(0));
    tick; op_in(OP_SH, 32'h201, 32'h0, 1'b0); #1;
    chk("ades_exc",  64'(exc_o), 64'(EXC_ADES));
    chk("ades_dreq", 64'(dreq_o), 64'(0));
    tick; op_in(OP_LW, 32'h300, 32'h0, 1'b1); exc = 5'h0C; #1;
    chk("uexc_exc",  64'(exc_o), 64'(5'h0C));
    chk("uexc_dreq", 64'(dreq_o), 64'(0));
    chk("uexc_wreg", 64'(wreg_o), 64'(0));
    exc = EXC_NONE;

    // Flush while waiting: request held until the late ack, no writeback.
    tick; op_in(OP_LW, 32'h300, 32'h0, 1'b1); #1;
    chk("fw_c0_dreq", 64'(dreq_o), 64'(1));
    tick; #1; chk("fw_c1_dreq", 64'(dreq_o), 64'(1));
    tick; flush = 1'b1; op_in(OP_LW, 32'h308, 32'h0, 1'b1); #1;
    chk("fw_c2_dreq", 64'(dreq_o), 64'(1));
    chk("fw_c2_addr", 64'(daddr_o), 64'(32'h300));
    chk("fw_c2_wreg", 64'(wreg_o), 64'(0));
    tick; flush = 1'b0; op_in(OP_ADD, 32'h55, 32'h0, 1'b1); #1;
    chk("fw_c3_dreq",  64'(dreq_o), 64'(1));
    chk("fw_c3_stall", 64'(stall_o), 64'(1));
    chk("fw_c3_wreg",  64'(wreg_o), 64'(0));
    chk("fw_c3_addr",  64'(daddr_o), 64'(32'h300));
    tick; #1; chk("fw_c4_dreq", 64'(dreq_o), 64'(1));
    tick; bus_in(1'b1, 32'h1111_1111); #1;
    chk("fw_c5_dreq",  64'(dreq_o), 64'(1));
    tick; bus_in(1'b0, 32'h0); #1;
    chk("fw_c6_dreq",  64'(dreq_o), 64'(0));
    chk("fw_c6_stall", 64'(stall_o), 64'(0));
    chk("fw_c6_wreg",  64'(wreg_o), 64'(1));
    chk("fw_c6_dreg",  64'(dreg_o), 64'(32'h55));

    // Ack while the pipeline is held: DONE keeps the captured word.
    tick; op_in(OP_LW, 32'h400, 32'h0, 1'b1); bus_in(1'b1, 32'h1122_3344); adv = 1'b0; #1;
    chk("dn_c0_dreg",  64'(dreg_o), 64'(32'h1122_3344));
    chk("dn_c0_stall", 64'(stall_o), 64'(0));
    tick; bus_in(1'b0, 32'hAAAA_AAAA); #1;
    chk("dn_c1_dreq",  64'(dreq_o), 64'(0));
    chk("dn_c1_dreg",  64'(dreg_o), 64'(32'h1122_3344));
    tick; rdata = 32'h5555_5555; #1;
    chk("dn_c2_dreg",  64'(dreg_o), 64'(32'h1122_3344));
    tick; adv = 1'b1; #1;
    chk("dn_c3_dreg",  64'(dreg_o), 64'(32'h1122_3344));
    chk("dn_c3_dreq",  64'(dreq_o), 64'(0));
    tick; op_in(OP_LW, 32'h404, 32'h0, 1'b1); #1;
    chk("dn_c4_dreq",  64'(dreq_o), 64'(1));
    chk("dn_c4_stall", 64'(stall_o), 64'(1));
    tick; bus_in(1'b1, 32'h0A0B_0C0D); #1;
    chk("dn_c5_dreg",  64'(dreg_o), 64'(32'h0A0B_0C0D));

    // Reset while waiting, then a late ack that must be ignored.
    tick; op_in(OP_LW, 32'h500, 32'h0, 1'b1); bus_in(1'b0, 32'h0); #1;
    chk("rw_c0_stall", 64'(stall_o), 64'(1));
    tick; #1;
    chk("rw_c1_addr",  64'(daddr_o), 64'(32'h500));
    #2; rst = 1'b1; #1;
    chk("rw_rst_dreq",  64'(dreq_o), 64'(0));
    chk("rw_rst_stall", 64'(stall_o), 64'(0));
    chk("rw_rst_addr",  64'(daddr_o), 64'(0));
    chk("rw_rst_dreg",  64'(dreg_o), 64'(0));
    chk("rw_rst_wreg",  64'(wreg_o), 64'(0));
    chk("rw_rst_exc",   64'(exc_o), 64'(EXC_NONE));
    tick; rst = 1'b0; op_in(OP_ADD, 32'h77, 32'h0, 1'b1); bus_in(1'b1, 32'h99); #1;
    chk("late_stall", 64'(stall_o), 64'(0));
    chk("late_dreq",  64'(dreq_o), 64'(0));
    chk("late_dreg",  64'(dreg_o), 64'(32'h77));
    tick; op_in(OP_LW, 32'h600, 32'h0, 1'b1); bus_in(1'b0, 32'h0); #1;
    chk("post_dreq",  64'(dreq_o), 64'(1));
    chk("post_stall", 64'(stall_o), 64'(1));
    tick; bus_in(1'b1, 32'hCAFE_F00D); #1;
    chk("post_dreg",  64'(dreg_o), 64'(32'hCAFE_F00D));
    chk("post_stall2", 64'(stall_o), 64'(0));
    tick; op_in(OP_ADD, 32'h0, 32'h0, 1'b0); bus_in(1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameters: none; widths come from the shared package (REG_BUS 32, DOUBLE_REG_BUS 64, REG_ADDR_BUS 5, ALUOP_BUS 8, EXC_CODE_BUS 5).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset: cpu_clk_50M  in  1  clock; cpu_rst  in  1  asynchronous active-high reset.
REQ-003 mem_aluop_i  in  8  internal opcode from the execute stage.
REQ-004 mem_wa_i / mem_wreg_i / mem_mreg_i  in  5/1/1  destination register, write enable, load-to-register flag.
REQ-005 mem_wd_i  in  32  ALU result, or effective address for loads and stores.
REQ-006 mem_din_i  in  32  store data.
REQ-007 mem_whilo_i / mem_hilo_i  in  1/64  HI/LO write enable and value.
REQ-008 mem_exccode_i  in  5  upstream exception code; EXC_NONE means no exception.
REQ-009 flush_i  in  1  squash the current instruction.
REQ-010 adv_i  in  1  pipeline advances this cycle (no stall from other stages).
REQ-011 dreq_o / dwe_o / daddr_o / dbe_o / dwdata_o  out  1/1/32/4/32  data-bus request, write, word address, byte enables, write data.
REQ-012 dack_i / drdata_i  in  1/32  bus acknowledge and read word.
REQ-013 mem_wa_o / mem_wreg_o / mem_mreg_o / mem_dreg_o  out  5/1/1/32  writeback register, enable, load flag, result.
REQ-014 mem_whilo_o / mem_hilo_o  out  1/64  HI/LO writeback; mem2exe_whilo / mem2exe_hilo  out  1/64  forwarding copies of the same signals.
REQ-015 mem_exccode_o  out  5  final exception code; stallreq_mem  out  1  stall request to the pipeline controller.

Function
REQ-016 mem_op SHALL be true for LB, LBU, LH, LHU, LW, SB, SH and SW when mem_exccode_i is EXC_NONE, the access is aligned and flush_i is 0.
REQ-017 Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0, SHALL set exccode to ADEL (loads) or ADES (stores), issue no bus request, and force mem_wreg_o to 0.
REQ-018 Byte enables: SB sets one bit selected by addr[1:0], e.g. addr 3 gives 4'b1000; SH sets 4'b0011 or 4'b1100; SW sets 4'b1111; loads set 4'b1111; dwdata_o carries the byte or halfword replicated across lanes.
REQ-019 daddr_o SHALL be {addr[31:2],2'b00}.
REQ-020 FSM states: IDLE, WAIT, DONE, DRAIN.
REQ-021 IDLE: dreq_o = mem_op, driven combinationally.
  - mem_op & dack_i (same cycle): go to DONE if adv_i=0, otherwise stay in IDLE.
  - mem_op & !dack_i: go to WAIT.
REQ-022 WAIT: hold dreq_o and all bus outputs stable.
  - dack_i: go to DONE if adv_i=0, otherwise IDLE.
  - flush_i without dack_i: go to DRAIN.
REQ-023 DRAIN: hold dreq_o until dack_i, then go to IDLE; discard the data; mem_wreg_o = 0.
REQ-024 DONE: dreq_o = 0; the captured read word is held in rdata_q; return to IDLE when adv_i=1.
REQ-025 On every dack_i cycle, rdata_q SHALL capture drdata_i.
REQ-026 stallreq_mem SHALL be 1 in IDLE when mem_op & !dack_i, throughout WAIT and throughout DRAIN; it SHALL be 0 otherwise.
REQ-027 Load result: mem_dreg_o = ext(lane(dack_i ? drdata_i : rdata_q)), where lane selection is by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend.
REQ-028 For non-load instructions, mem_dreg_o SHALL equal mem_wd_i.
REQ-029 mem_wreg_o SHALL be mem_wreg_i & !flush_i & no exception.
REQ-030 mem_whilo_o SHALL be gated the same way as mem_wreg_o.
REQ-031 All other outputs SHALL pass through combinationally from their inputs.
REQ-032 A bus request, once raised, SHALL never be withdrawn before dack_i, including on flush.

Reset
REQ-033 While cpu_rst=1, the block SHALL force:
  - state = IDLE;
  - rdata_q = 0;
  - all outputs 0, and mem_exccode_o = EXC_NONE.
REQ-034 Reset mid-transaction (WAIT or DRAIN) SHALL abandon the transaction immediately; a late dack_i after reset SHALL be ignored in IDLE when mem_op=0.

Structure
REQ-035 The shared package SHALL hold the aluop codes, the EXC_* codes, the FSM state encodings and the bus widths.
REQ-036 One sub-module, load_align, SHALL implement lane selection and extension combinationally (addr[1:0], aluop, word -> 32-bit result).

Verification
REQ-037 Zero-wait LW: addr 0x100, dack_i in the same cycle with drdata 0xDEADBEEF -> mem_dreg_o=0xDEADBEEF, stallreq_mem never 1.
REQ-038 LB with 3-cycle ack: addr 0x103, drdata 0x80FFFFFF -> stallreq_mem high 3 cycles, mem_dreg_o=0xFFFFFF80; repeat with LBU -> 0x00000080.
REQ-039 SH: addr 0x202, din 0x1234ABCD -> dbe_o=4'b1100, dwdata_o=0xABCDABCD, dwe_o=1, mem_wreg_o=0.
REQ-040 Misaligned LW at addr 0x101 -> dreq_o never asserted, exccode=ADEL, mem_wreg_o=0.
REQ-041 Flush in WAIT: flush_i at cycle 2, dack_i at cycle 5 -> dreq_o held through cycle 5, then IDLE, no writeback.
REQ-042 Ack with adv_i=0 for 2 cycles -> DONE holds mem_dreg_o stable even with drdata_i changing; reset asserted in WAIT -> IDLE and all outputs 0 immediately.
